// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the dual-master memory port arbiter.
// Master identifiers, default widths and the read-latency legality check live here.
package mem_port_arbiter_pkg;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

    function automatic bit read_latency_legal(input int lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

    function automatic mst_e other_master(input mst_e m);
        return (m == MST_M0) ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from a registered priority bit.
// After a contested grant the priority moves to the loser; uncontested grants leave it alone.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    mst_e       prio_r;
    logic [1:0] gnt_s;

    // Grant selection; nothing is granted while reset is asserted
    always_comb begin
        gnt_s = 2'b00;
        if (!rst_n) begin
            gnt_s = 2'b00;
        end else begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (prio_r == MST_M0) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    // Priority register: the winner of a contested grant hands priority to the loser
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r <= MST_M0;
        end else if (req == 2'b11) begin
            prio_r <= other_master(prio_r);
        end else begin
            prio_r <= prio_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one dual-port memory between a data master (M0) and an instruction/loader master (M1).
// Read and write ports are arbitrated independently; read data returns READ_LATENCY cycles after grant.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int READ_LATENCY = 1,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [ADDR_W-1:0]      m0_addr,
    input  logic [DATA_W-1:0]      m0_wdata,
    output logic                   m0_gnt,
    output logic                   m0_rvalid,
    output logic [DATA_W-1:0]      m0_rdata,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [ADDR_W-1:0]      m1_addr,
    input  logic [DATA_W-1:0]      m1_wdata,
    output logic                   m1_gnt,
    output logic                   m1_rvalid,
    output logic [DATA_W-1:0]      m1_rdata,
    output logic                   mem_r_en,
    output logic [ADDR_W-1:0]      mem_r_addr,
    input  logic [DATA_W-1:0]      mem_r_data,
    output logic                   mem_w_en,
    output logic [ADDR_W-1:0]      mem_w_addr,
    output logic [DATA_W-1:0]      mem_w_data,
    output logic [STALL_CNT_W-1:0] dbg_stall_cnt
);

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("mem_port_arbiter: READ_LATENCY must be 1 or 2");
    end

    logic [1:0]              rd_req_s;
    logic [1:0]              wr_req_s;
    logic [1:0]              rd_gnt_s;
    logic [1:0]              wr_gnt_s;
    logic                    stall_s;
    logic [READ_LATENCY-1:0] own_vld_r;
    mst_e                    own_id_r [READ_LATENCY];
    logic [STALL_CNT_W-1:0]  stall_cnt_r;

    assign rd_req_s = {m1_req & ~m1_we, m0_req & ~m0_we};
    assign wr_req_s = {m1_req &  m1_we, m0_req &  m0_we};

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req_s),
        .gnt   (rd_gnt_s)
    );

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req_s),
        .gnt   (wr_gnt_s)
    );

    // A master issues one operation per cycle, so at most one of its port grants is set
    assign m0_gnt = rd_gnt_s[0] | wr_gnt_s[0];
    assign m1_gnt = rd_gnt_s[1] | wr_gnt_s[1];

    // Read-port mux: idle port drives zeros
    always_comb begin
        mem_r_en   = 1'b0;
        mem_r_addr = {ADDR_W{1'b0}};
        if (rd_gnt_s[0]) begin
            mem_r_en   = 1'b1;
            mem_r_addr = m0_addr;
        end else if (rd_gnt_s[1]) begin
            mem_r_en   = 1'b1;
            mem_r_addr = m1_addr;
        end else begin
            mem_r_en   = 1'b0;
            mem_r_addr = {ADDR_W{1'b0}};
        end
    end

    // Write-port mux: idle port drives zeros
    always_comb begin
        mem_w_en   = 1'b0;
        mem_w_addr = {ADDR_W{1'b0}};
        mem_w_data = {DATA_W{1'b0}};
        if (wr_gnt_s[0]) begin
            mem_w_en   = 1'b1;
            mem_w_addr = m0_addr;
            mem_w_data = m0_wdata;
        end else if (wr_gnt_s[1]) begin
            mem_w_en   = 1'b1;
            mem_w_addr = m1_addr;
            mem_w_data = m1_wdata;
        end else begin
            mem_w_en   = 1'b0;
            mem_w_addr = {ADDR_W{1'b0}};
            mem_w_data = {DATA_W{1'b0}};
        end
    end

    // Owner pipeline tracks which master each in-flight read belongs to; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            own_vld_r <= {READ_LATENCY{1'b0}};
            for (int i = 0; i < READ_LATENCY; i++) begin
                own_id_r[i] <= MST_M0;
            end
        end else begin
            own_vld_r[0] <= |rd_gnt_s;
            own_id_r[0]  <= rd_gnt_s[1] ? MST_M1 : MST_M0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                own_vld_r[i] <= own_vld_r[i-1];
                own_id_r[i]  <= own_id_r[i-1];
            end
        end
    end

    assign m0_rvalid = rst_n & own_vld_r[READ_LATENCY-1] & (own_id_r[READ_LATENCY-1] == MST_M0);
    assign m1_rvalid = rst_n & own_vld_r[READ_LATENCY-1] & (own_id_r[READ_LATENCY-1] == MST_M1);
    assign m0_rdata  = mem_r_data;
    assign m1_rdata  = mem_r_data;

    assign stall_s = (m0_req & ~m0_gnt) | (m1_req & ~m1_gnt);

    // Saturating count of cycles in which some request waited
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign dbg_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two builds (latency 1 / 16-bit counter, latency 2 / 4-bit counter)
// driven in lockstep and compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic [1:0]  m0_gnt_o, m1_gnt_o, m0_rv_o, m1_rv_o, r_en_o, w_en_o;
    logic [31:0] m0_rd_o [2];
    logic [31:0] m1_rd_o [2];
    logic [31:0] r_addr_o [2];
    logic [31:0] w_addr_o [2];
    logic [31:0] w_data_o [2];
    logic [31:0] mem_rd_i [2];
    logic [15:0] dbg_a;
    logic [3:0]  dbg_b;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .STALL_CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_o[0]), .m0_rvalid(m0_rv_o[0]), .m0_rdata(m0_rd_o[0]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_o[0]), .m1_rvalid(m1_rv_o[0]), .m1_rdata(m1_rd_o[0]),
        .mem_r_en(r_en_o[0]), .mem_r_addr(r_addr_o[0]), .mem_r_data(mem_rd_i[0]),
        .mem_w_en(w_en_o[0]), .mem_w_addr(w_addr_o[0]), .mem_w_data(w_data_o[0]),
        .dbg_stall_cnt(dbg_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(2), .STALL_CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt_o[1]), .m0_rvalid(m0_rv_o[1]), .m0_rdata(m0_rd_o[1]),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt_o[1]), .m1_rvalid(m1_rv_o[1]), .m1_rdata(m1_rd_o[1]),
        .mem_r_en(r_en_o[1]), .mem_r_addr(r_addr_o[1]), .mem_r_data(mem_rd_i[1]),
        .mem_w_en(w_en_o[1]), .mem_w_addr(w_addr_o[1]), .mem_w_data(w_data_o[1]),
        .dbg_stall_cnt(dbg_b)
    );

    // Memory instances seen by each build: read-before-write, 1- and 2-cycle read pipes
    logic [31:0] bmem [2][256];
    logic [31:0] rd_s1 [2];
    logic [31:0] rd_s2 [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) bmem[d][i] <= 32'hA000_0000 + 32'(i);
            end else if (w_en_o[d]) begin
                bmem[d][w_addr_o[d][7:0]] <= w_data_o[d];
            end
            if (r_en_o[d]) rd_s1[d] <= bmem[d][r_addr_o[d][7:0]];
            rd_s2[d] <= rd_s1[d];
        end
    end
    assign mem_rd_i[0] = rd_s1[0];
    assign mem_rd_i[1] = rd_s2[1];

    // ---------------- reference model ----------------
    typedef struct {
        int          gcyc;
        int          owner;
        logic [31:0] data;
    } rd_t;

    rd_t         pend [$];
    logic [31:0] mmem [256];
    int          cyc;
    int          rd_prio, wr_prio;
    int          stall_m [2];
    int          stall_max [2] = '{65535, 15};
    int          lat [2] = '{1, 2};
    bit          last_eg0, last_eg1;
    int          n_cmp, n_mis;

    logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_rv0b, obs_rv1b;
    logic [31:0] obs_rd0, obs_rd1, obs_rd0b;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit c0, input bit c1, input int prio);
        if (!rst_n)        return -1;
        if (c0 && c1)      return prio;
        if (c0)            return 0;
        if (c1)            return 1;
        return -1;
    endfunction

    // One clock: check all outputs at the falling edge, advance the model at the rising edge
    task automatic cycle();
        int          rw, ww;
        bit          rc0, rc1, wc0, wc1, eg0, eg1, ev0, ev1, stalled;
        logic [31:0] ed, dbgv;
        @(negedge clk);
        rc0 = m0_req && !m0_we;  rc1 = m1_req && !m1_we;
        wc0 = m0_req &&  m0_we;  wc1 = m1_req &&  m1_we;
        rw  = pick(rc0, rc1, rd_prio);
        ww  = pick(wc0, wc1, wr_prio);
        eg0 = (rw == 0) || (ww == 0);
        eg1 = (rw == 1) || (ww == 1);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d m0_gnt", d), 32'(m0_gnt_o[d]), 32'(eg0));
            chk($sformatf("dut%0d m1_gnt", d), 32'(m1_gnt_o[d]), 32'(eg1));
            chk($sformatf("dut%0d mem_r_en", d), 32'(r_en_o[d]), 32'(rw >= 0));
            chk($sformatf("dut%0d mem_r_addr", d), r_addr_o[d],
                (rw == 0) ? m0_addr : (rw == 1) ? m1_addr : 32'h0);
            chk($sformatf("dut%0d mem_w_en", d), 32'(w_en_o[d]), 32'(ww >= 0));
            chk($sformatf("dut%0d mem_w_addr", d), w_addr_o[d],
                (ww == 0) ? m0_addr : (ww == 1) ? m1_addr : 32'h0);
            chk($sformatf("dut%0d mem_w_data", d), w_data_o[d],
                (ww == 0) ? m0_wdata : (ww == 1) ? m1_wdata : 32'h0);
            ev0 = 1'b0; ev1 = 1'b0; ed = 32'h0;
            foreach (pend[k]) begin
                if (rst_n && (pend[k].gcyc + lat[d] == cyc)) begin
                    if (pend[k].owner == 0) ev0 = 1'b1; else ev1 = 1'b1;
                    ed = pend[k].data;
                end
            end
            chk($sformatf("dut%0d m0_rvalid", d), 32'(m0_rv_o[d]), 32'(ev0));
            chk($sformatf("dut%0d m1_rvalid", d), 32'(m1_rv_o[d]), 32'(ev1));
            if (ev0) chk($sformatf("dut%0d m0_rdata", d), m0_rd_o[d], ed);
            if (ev1) chk($sformatf("dut%0d m1_rdata", d), m1_rd_o[d], ed);
            dbgv = (d == 0) ? 32'(dbg_a) : 32'(dbg_b);
            chk($sformatf("dut%0d dbg_stall_cnt", d), dbgv, 32'(stall_m[d]));
        end
        obs_g0 = m0_gnt_o[0]; obs_g1 = m1_gnt_o[0];
        obs_rv0 = m0_rv_o[0]; obs_rv1 = m1_rv_o[0];
        obs_rd0 = m0_rd_o[0]; obs_rd1 = m1_rd_o[0];
        obs_rv0b = m0_rv_o[1]; obs_rv1b = m1_rv_o[1]; obs_rd0b = m0_rd_o[1];
        last_eg0 = eg0; last_eg1 = eg1;

        @(posedge clk);
        if (!rst_n) begin
            rd_prio = 0; wr_prio = 0;
            pend.delete();
            stall_m[0] = 0; stall_m[1] = 0;
        end else begin
            stalled = (m0_req && !eg0) || (m1_req && !eg1);
            for (int d = 0; d < 2; d++)
                if (stalled && stall_m[d] < stall_max[d]) stall_m[d]++;
            if (rc0 && rc1) rd_prio = 1 - rw;
            if (wc0 && wc1) wr_prio = 1 - ww;
            if (rw >= 0) pend.push_back(rd_t'{cyc, rw, mmem[((rw == 0) ? m0_addr[7:0] : m1_addr[7:0])]});
            if (ww >= 0) mmem[(ww == 0) ? m0_addr[7:0] : m1_addr[7:0]] = (ww == 0) ? m0_wdata : m1_wdata;
        end
        cyc++;
        while (pend.size() > 0 && pend[0].gcyc + 2 < cyc) void'(pend.pop_front());
        #1;
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    typedef struct {
        bit          rst;
        bit          r0, w0;
        logic [31:0] a0, d0;
        bit          r1, w1;
        logic [31:0] a1, d1;
        bit          eg0, eg1, ev0, ev1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // rst, m0{req,we,addr,wdata}, m1{req,we,addr,wdata}, expected gnt0,gnt1,rvalid0,rvalid1 (latency-1 build)
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 32'h80, 32'h1, 1'b1, 1'b1, 32'h80, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h80, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b1, 1'b0};

        n_cmp = 0; n_mis = 0; cyc = 0; rd_prio = 0; wr_prio = 0;
        stall_m[0] = 0; stall_m[1] = 0;
        for (int i = 0; i < 256; i++) mmem[i] = 32'hA000_0000 + 32'(i);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0; mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;

        // Reset, read/read alternation, write/write contention
        for (int v = 0; v < 11; v++) begin
            rst_n = tbl[v].rst;
            drive(tbl[v].r0, tbl[v].w0, tbl[v].a0, tbl[v].d0, tbl[v].r1, tbl[v].w1, tbl[v].a1, tbl[v].d1);
            cycle();
            chk($sformatf("vec%0d m0_gnt", v), 32'(obs_g0), 32'(tbl[v].eg0));
            chk($sformatf("vec%0d m1_gnt", v), 32'(obs_g1), 32'(tbl[v].eg1));
            chk($sformatf("vec%0d m0_rvalid", v), 32'(obs_rv0), 32'(tbl[v].ev0));
            chk($sformatf("vec%0d m1_rvalid", v), 32'(obs_rv1), 32'(tbl[v].ev1));
        end
        chk("ww final mem[0x80]", obs_rd0, 32'h2);
        chk("stall after table", 32'(dbg_a), 32'd5);

        // Read/write split on the same address: old data first, new data on the next read
        drive(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 1'b1, 1'b0, 32'h40, 32'h0);
        cycle();
        chk("split m0_gnt", 32'(obs_g0), 32'h1);
        chk("split m1_gnt", 32'(obs_g1), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        cycle();
        chk("split old rvalid", 32'(obs_rv1), 32'h1);
        chk("split old rdata", obs_rd1, 32'hA000_0040);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("split new rvalid", 32'(obs_rv1), 32'h1);
        chk("split new rdata", obs_rd1, 32'hDEADBEEF);
        cycle();

        // Reset while a read is in flight: the data is dropped in both builds
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
        cycle();
        chk("midrst gnt", 32'(obs_g1), 32'h1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        cycle();
        chk("midrst rvalid lat1", 32'(obs_rv1), 32'h0);
        rst_n = 1'b1;
        cycle();
        chk("midrst rvalid lat2", 32'(obs_rv1b), 32'h0);
        chk("midrst stall cleared", 32'(dbg_a), 32'h0);

        // Stall counter saturation on the 4-bit build
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int n = 0; n < 20; n++) cycle();
        chk("sat 4-bit", 32'(dbg_b), 32'd15);
        chk("sat 16-bit", 32'(dbg_a), 32'd20);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 3; n++) cycle();

        // Latency-2 build: rvalid only at grant+2
        drive(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        cycle();
        chk("lat2 rvalid +1", 32'(obs_rv0b), 32'h0);
        cycle();
        chk("lat2 rvalid +2", 32'(obs_rv0b), 32'h1);
        chk("lat2 rdata", obs_rd0b, 32'hA000_0008);
        cycle();

        // Random traffic with held requests and occasional reset
        for (int n = 0; n < 400; n++) begin
            if (!(m0_req && !last_eg0)) begin
                m0_req   = ($urandom_range(0, 3) != 0);
                m0_we    = 1'($urandom_range(0, 1));
                m0_addr  = 32'($urandom_range(0, 7)) * 32'd4;
                m0_wdata = $urandom;
            end
            if (!(m1_req && !last_eg1)) begin
                m1_req   = ($urandom_range(0, 3) != 0);
                m1_we    = 1'($urandom_range(0, 1));
                m1_addr  = 32'($urandom_range(0, 7)) * 32'd4;
                m1_wdata = $urandom;
            end
            rst_n = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
